addsub_div_seq: RTL and testbench

ADDSUB_DIV_SEQ -- requirements
Module: addsub_div_seq

---
 rtl/addsub_div_seq.sv | 120 ++++++++++++
 tb/tb_addsub_div_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_div_seq.sv
// Sequential unsigned divider (restoring, one quotient bit per cycle) that borrows
// an external shared adder/subtractor for the trial subtraction.
module addsub_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] addsub_a_o,
    output logic [WIDTH-1:0] addsub_b_o,
    output logic             addsub_sub_o,
    output logic             addsub_en_o,
    input  logic [WIDTH-1:0] addsub_sum_i,
    input  logic             addsub_cout_i
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_d, remainder_d;
    logic             dbz_d;
    logic [WIDTH-1:0] shifted;
    logic             sub_ok;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_o;
        remainder_d = remainder_o;
        dbz_d       = div_by_zero_o;
        addsub_a_o   = '0;
        addsub_b_o   = '0;
        addsub_sub_o = 1'b0;
        addsub_en_o  = 1'b0;

        // The bit shifted out of R is an implicit 33rd bit: if set, S exceeds any divisor.
        shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        sub_ok  = rem_q[WIDTH-1] | addsub_cout_i;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (divisor_i != '0) begin
                        quo_d   = dividend_i;
                        dsr_d   = divisor_i;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = ITER;
                    end else begin
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            ITER: begin
                addsub_a_o   = shifted;
                addsub_b_o   = dsr_q;
                addsub_sub_o = 1'b1;
                addsub_en_o  = 1'b1;
                rem_d = sub_ok ? addsub_sum_i : shifted;
                quo_d = {quo_q[WIDTH-2:0], sub_ok};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            quo_q         <= '0;
            dsr_q         <= '0;
            cnt_q         <= '0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dsr_q         <= dsr_d;
            cnt_q         <= cnt_d;
            quotient_o    <= quotient_d;
            remainder_o   <= remainder_d;
            div_by_zero_o <= dbz_d;
        end
    end

endmodule

// File: tb/tb_addsub_div_seq.sv
// Scoreboard bench for addsub_div_seq: stimulus pushes expected results computed with
// plain / and %, a negedge monitor pops and compares on every done_o pulse.
module tb_addsub_div_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] dividend_i, divisor_i;
    logic        busy_o, done_o, div_by_zero_o;
    logic [31:0] quotient_o, remainder_o;
    logic [31:0] addsub_a_o, addsub_b_o, addsub_sum_i;
    logic        addsub_sub_o, addsub_en_o, addsub_cout_i;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          done_cyc;
        int          iters;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   idle_viol = 0;

    addsub_div_seq #(.WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o),
        .addsub_a_o    (addsub_a_o),
        .addsub_b_o    (addsub_b_o),
        .addsub_sub_o  (addsub_sub_o),
        .addsub_en_o   (addsub_en_o),
        .addsub_sum_i  (addsub_sum_i),
        .addsub_cout_i (addsub_cout_i)
    );

    // Shared adder/subtractor the divider borrows: a + b, or a + ~b + 1 when sub is set.
    logic [32:0] add_full;
    always_comb begin
        add_full = addsub_sub_o ? ({1'b0, addsub_a_o} + {1'b0, ~addsub_b_o} + 33'd1)
                                : ({1'b0, addsub_a_o} + {1'b0, addsub_b_o});
    end
    assign addsub_sum_i  = add_full[31:0];
    assign addsub_cout_i = add_full[32];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done_o pulse.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rst_i) begin
            en_cnt = 0;
        end else begin
            if (addsub_en_o) en_cnt++;
            if ((!busy_o || done_o) &&
                (addsub_en_o || addsub_sub_o || addsub_a_o != 0 || addsub_b_o != 0))
                idle_viol++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", quotient_o, e.q);
                    check("remainder", remainder_o, e.r);
                    check("div_by_zero", {31'd0, div_by_zero_o}, {31'd0, e.dbz});
                    check("done_cycle", cyc, e.done_cyc);
                    check("en_cycles", en_cnt, e.iters);
                end
                en_cnt = 0;
            end
        end
    end

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d, input int accept);
        exp_t e;
        e.q        = (d == 0) ? 32'hFFFF_FFFF : a / d;
        e.r        = (d == 0) ? a : a % d;
        e.dbz      = (d == 0);
        e.done_cyc = accept + ((d == 0) ? 0 : 32);
        e.iters    = (d == 0) ? 0 : 32;
        return e;
    endfunction

    // Presents one operation for a single cycle and waits until the divider is idle again.
    task automatic issue(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = d;
        sb.push_back(model(a, d, cyc + 1));
        @(negedge clk_i);
        start_i    = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        if (d != 0) repeat (32) @(negedge clk_i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check({tag, "_quotient"}, quotient_o, 32'd0);
        check({tag, "_remainder"}, remainder_o, 32'd0);
        check({tag, "_dbz"}, {31'd0, div_by_zero_o}, 32'd0);
        check({tag, "_en"}, {31'd0, addsub_en_o}, 32'd0);
        check({tag, "_sub"}, {31'd0, addsub_sub_o}, 32'd0);
        check({tag, "_a"}, addsub_a_o, 32'd0);
        check({tag, "_b"}, addsub_b_o, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("por");
        rst_i = 1'b0;

        // Directed cases, including the shifted-out MSB path and zero divisor.
        issue(32'd100, 32'd7);
        issue(32'hFFFF_FFFF, 32'h8000_0001);
        issue(32'h1234_5678, 32'd0);
        issue(32'd0, 32'd5);
        issue(32'd3, 32'd10);
        issue(32'hFFFF_FFFF, 32'd1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // start_i held high for three back-to-back operations; operands churn while busy.
        @(negedge clk_i);
        start_i = 1'b1;
        for (int op = 0; op < 3; op++) begin
            dividend_i = 32'd5;
            divisor_i  = 32'd3;
            sb.push_back(model(32'd5, 32'd3, cyc + 1));
            for (int j = 0; j < 34; j++) begin
                @(negedge clk_i);
                dividend_i = $urandom;
                divisor_i  = $urandom;
            end
        end
        start_i = 1'b0;

        // Random operands biased toward the interesting corners.
        for (int n = 0; n < 1200; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       d = 32'd0;
                1:       d = 32'd1;
                2:       begin d = $urandom | 32'h1; a = a % d; end
                3:       d = $urandom_range(2, 255);
                4:       d = $urandom | 32'h8000_0000;
                default: d = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            issue(a, d);
        end

        // Reset in the middle of an operation: no done, outputs cleared, then a clean restart.
        @(negedge clk_i);
        start_i    = 1'b1;
        dividend_i = 32'd200;
        divisor_i  = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("mid_iter_rst");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        issue(32'd9, 32'd9);

        repeat (40) @(negedge clk_i);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("addsub_idle_violations", idle_viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
